// File: rtl/inst_mem_pkg.sv
// Shared constants, address/parity helpers and the pipeline stage record for inst_mem_sync.
// Optional feature macro: INST_MEM_PARITY_EN.
package inst_mem_pkg;

    localparam logic [31:0] FILL_WORD_C = 32'h8000_0000;

    // Widest instruction a pipeline stage record carries.
    localparam int unsigned INST_W = 32;

    typedef struct packed {
        logic              valid;
        logic              err;
        logic [INST_W-1:0] data;
    } stage_t;

    // Returns {in_range, aligned} for a byte address against a word depth.
    function automatic logic [1:0] addr_check(input logic [63:0] addr, input int unsigned depth);
        logic in_range;
        logic aligned;
        in_range = addr < (64'(depth) << 2);
        aligned  = addr[1:0] == 2'b00;
        return {in_range, aligned};
    endfunction

    // Even-parity bit: makes the total number of ones across word+bit even.
    function automatic logic parity_even(input logic [63:0] w);
        return ^w;
    endfunction

endpackage

// File: rtl/inst_mem_array.sv
// Instruction storage: one write port, one registered read port; no reset on the array itself.
// With INST_MEM_PARITY_EN a parity column is stored alongside each word and checked on read.
module inst_mem_array
    import inst_mem_pkg::*;
#(
    parameter int unsigned DEPTH  = 128,
    parameter int unsigned DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_widx,
    input  logic [DATA_W-1:0]        i_wdata,
    input  logic                     i_re,
    input  logic [$clog2(DEPTH)-1:0] i_ridx,
    output logic [DATA_W-1:0]        o_rdata,
    output logic                     o_rpar_ok
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_widx] <= i_wdata;
        end
    end

    // Read register holds its value when no read is issued so stalled outputs stay frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_ridx];
        end
    end

    assign o_rdata = r_rdata;

`ifdef INST_MEM_PARITY_EN
    logic r_par [DEPTH];
    logic r_rpar;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_par[i_widx] <= parity_even(64'(i_wdata));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rpar <= 1'b0;
        end else if (i_re) begin
            r_rpar <= r_par[i_ridx];
        end
    end

    assign o_rpar_ok = parity_even(64'(r_rdata)) == r_rpar;
`else
    assign o_rpar_ok = 1'b1;
`endif

endmodule

// File: rtl/inst_mem_sync.sv
// Synchronous instruction memory: fetch handshake, stall/flush control, 1- or 2-cycle read pipeline
// and a run-time program load port. Optional parity checking via INST_MEM_PARITY_EN.
module inst_mem_sync
    import inst_mem_pkg::*;
#(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DEPTH     = 128,
    parameter int unsigned       READ_LAT  = 1,
    parameter logic [DATA_W-1:0] FILL_WORD = DATA_W'(FILL_WORD_C)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    input  logic              if_stall,
    input  logic              if_flush,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_data,
    output logic              if_err,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic              w_acc;
    logic [1:0]        w_if_chk;
    logic [1:0]        w_ld_chk;
    logic              w_if_ok;
    logic              w_ld_ok;
    logic [DATA_W-1:0] w_rdata;
    logic              w_rpar_ok;
    logic [DATA_W-1:0] w_s1_data;
    logic              w_s1_err;

    logic              r_s1_valid;
    logic              r_s1_err;
    logic              r_ld_err;

    assign if_ready = !if_stall && !ld_we;
    assign w_acc    = if_req && if_ready;

    assign w_if_chk = addr_check(64'(if_addr), DEPTH);
    assign w_ld_chk = addr_check(64'(ld_addr), DEPTH);
    assign w_if_ok  = &w_if_chk;
    assign w_ld_ok  = &w_ld_chk;

    inst_mem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_array (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_we      (ld_we && w_ld_ok),
        .i_widx    (ld_addr[IDX_W+1:2]),
        .i_wdata   (ld_data),
        .i_re      (w_acc && w_if_ok),
        .i_ridx    (if_addr[IDX_W+1:2]),
        .o_rdata   (w_rdata),
        .o_rpar_ok (w_rpar_ok)
    );

    // Flush overrides stall; a fetch accepted in the flush cycle is the new target and survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_err   <= 1'b0;
        end else begin
            if (if_flush || !if_stall) begin
                r_s1_valid <= w_acc;
            end
            if (w_acc) begin
                r_s1_err <= !w_if_ok;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ld_err <= 1'b0;
        end else begin
            r_ld_err <= ld_we && !w_ld_ok;
        end
    end

    assign ld_err    = r_ld_err;
    assign w_s1_data = r_s1_err ? FILL_WORD : w_rdata;
    assign w_s1_err  = r_s1_err || !w_rpar_ok;

    generate
        if (READ_LAT == 2) begin : g_lat2
            stage_t r_s2;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_s2 <= '0;
                end else if (if_flush) begin
                    r_s2.valid <= 1'b0;
                end else if (!if_stall) begin
                    r_s2.valid <= r_s1_valid;
                    r_s2.err   <= w_s1_err;
                    r_s2.data  <= INST_W'(w_s1_data);
                end
            end

            assign if_valid = r_s2.valid;
            assign if_err   = r_s2.err;
            assign if_data  = DATA_W'(r_s2.data);
        end else begin : g_lat1
            assign if_valid = r_s1_valid;
            assign if_err   = w_s1_err;
            assign if_data  = w_s1_data;
        end
    endgenerate

endmodule

// File: tb/tb_inst_mem_sync.sv
// Bench for inst_mem_sync: READ_LAT=1 and READ_LAT=2 instances share stimulus and are checked
// against a queue-based reference model of accepted fetches.
module tb_inst_mem_sync;

    localparam int unsigned DEPTH = 128;
    localparam logic [31:0] FILL  = 32'h8000_0000;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        if_req   = 1'b0;
    logic [31:0] if_addr  = '0;
    logic        if_stall = 1'b0;
    logic        if_flush = 1'b0;
    logic        ld_we    = 1'b0;
    logic [31:0] ld_addr  = '0;
    logic [31:0] ld_data  = '0;

    logic        rdy  [2];
    logic        val  [2];
    logic [31:0] dat  [2];
    logic        err  [2];
    logic        lerr [2];

    int n_checks = 0;
    int n_errors = 0;

    inst_mem_sync #(.DEPTH(DEPTH), .READ_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr), .if_ready(rdy[0]),
        .if_stall(if_stall), .if_flush(if_flush), .if_valid(val[0]), .if_data(dat[0]),
        .if_err(err[0]), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .ld_err(lerr[0])
    );

    inst_mem_sync #(.DEPTH(DEPTH), .READ_LAT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr), .if_ready(rdy[1]),
        .if_stall(if_stall), .if_flush(if_flush), .if_valid(val[1]), .if_data(dat[1]),
        .if_err(err[1]), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .ld_err(lerr[1])
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          age;
    } pend_t;

    pend_t       q[$];
    logic [31:0] mem_m [DEPTH];
    logic        exp_v [2];
    logic [31:0] exp_d [2];
    logic        exp_e [2];
    logic        exp_le;

    function automatic bit legal(input logic [31:0] a);
        return (a < DEPTH * 4) && (a % 4 == 0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        q.delete();
        for (int k = 0; k < 2; k++) begin
            exp_v[k] = 1'b0;
            exp_d[k] = '0;
            exp_e[k] = 1'b0;
        end
        exp_le = 1'b0;
    endtask

    // Reference: each accepted fetch ages by one per unstalled edge and is shown at age == latency.
    task automatic model_edge();
        bit    acc;
        pend_t p;
        if (!rst_n) begin
            model_clear();
            return;
        end
        acc = if_req && !if_stall && !ld_we;
        if (if_flush) q.delete();
        if (acc) begin
            p.e   = !legal(if_addr);
            p.d   = p.e ? FILL : mem_m[if_addr / 4];
            p.age = 0;
            q.push_back(p);
        end
        if (if_flush || !if_stall) begin
            foreach (q[i]) q[i].age++;
            for (int k = 0; k < 2; k++) begin
                exp_v[k] = 1'b0;
                foreach (q[i]) begin
                    if (q[i].age == k + 1) begin
                        exp_v[k] = 1'b1;
                        exp_d[k] = q[i].d;
                        exp_e[k] = q[i].e;
                    end
                end
            end
            while (q.size() > 0 && q[0].age >= 2) void'(q.pop_front());
        end
        exp_le = ld_we && !legal(ld_addr);
        if (ld_we && legal(ld_addr)) mem_m[ld_addr / 4] = ld_data;
    endtask

    task automatic check_outs();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("valid_lat%0d", k + 1), 32'(val[k]), 32'(exp_v[k]));
            if (exp_v[k]) begin
                chk($sformatf("data_lat%0d", k + 1), dat[k], exp_d[k]);
                chk($sformatf("err_lat%0d", k + 1), 32'(err[k]), 32'(exp_e[k]));
            end
            chk($sformatf("ld_err_lat%0d", k + 1), 32'(lerr[k]), 32'(exp_le));
        end
    endtask

    task automatic cyc();
        #2;
        for (int k = 0; k < 2; k++)
            chk($sformatf("ready_lat%0d", k + 1), 32'(rdy[k]), 32'(!if_stall && !ld_we));
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outs();
    endtask

    task automatic idle();
        if_req   = 1'b0;
        if_stall = 1'b0;
        if_flush = 1'b0;
        ld_we    = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a);
        idle();
        if_req  = 1'b1;
        if_addr = a;
        cyc();
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        idle();
        ld_we   = 1'b1;
        ld_addr = a;
        ld_data = d;
        cyc();
    endtask

    task automatic idle_cycles(input int n);
        idle();
        for (int i = 0; i < n; i++) cyc();
    endtask

    logic [31:0] prog [4];

    initial begin
        model_clear();
        prog[0] = 32'h2002_0010;
        prog[1] = 32'h2003_000A;
        prog[2] = 32'h2007_0000;
        prog[3] = 32'h0000_0000;

        // Reset state
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_valid", 32'(val[k]), 32'd0);
            chk("rst_data", dat[k], 32'd0);
            chk("rst_err", 32'(err[k]), 32'd0);
            chk("rst_ld_err", 32'(lerr[k]), 32'd0);
        end
        rst_n = 1'b1;

        // Preload the whole array so every legal fetch has a known word
        for (int i = 0; i < int'(DEPTH); i++) load(32'(i * 4), $urandom);

        // Load-then-fetch program words
        for (int i = 0; i < 4; i++) load(32'(i * 4), prog[i]);
        for (int i = 0; i < 4; i++) fetch(32'(i * 4));
        idle_cycles(3);

        // Range and alignment
        fetch(32'h200);
        fetch(32'h6);
        idle_cycles(2);
        load(32'h201, 32'hDEAD_BEEF);
        idle_cycles(1);
        fetch(32'h0);
        idle_cycles(2);

        // Stall with two fetches in flight
        fetch(32'h4);
        fetch(32'h8);
        idle();
        if_stall = 1'b1;
        if_req   = 1'b1;
        if_addr  = 32'hC;
        for (int i = 0; i < 3; i++) cyc();
        idle_cycles(3);

        // Flush: 0x10 killed, 0x40 accepted in the flush cycle survives
        fetch(32'h10);
        idle();
        if_flush = 1'b1;
        if_req   = 1'b1;
        if_addr  = 32'h40;
        cyc();
        idle_cycles(3);

        // Flush overriding stall
        fetch(32'h14);
        fetch(32'h18);
        idle();
        if_flush = 1'b1;
        if_stall = 1'b1;
        cyc();
        idle_cycles(2);

        // Load priority over a simultaneous fetch
        idle();
        ld_we   = 1'b1;
        ld_addr = 32'h20;
        ld_data = 32'hCAFE_F00D;
        if_req  = 1'b1;
        if_addr = 32'h20;
        cyc();
        fetch(32'h20);
        idle_cycles(2);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            idle();
            if_req   = ($urandom_range(0, 99) < 70);
            if_addr  = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 1023))
                                                   : 32'($urandom_range(0, DEPTH - 1) * 4);
            if_stall = ($urandom_range(0, 99) < 20);
            if_flush = ($urandom_range(0, 99) < 10);
            ld_we    = ($urandom_range(0, 99) < 10);
            ld_addr  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 1023))
                                                   : 32'($urandom_range(0, DEPTH - 1) * 4);
            ld_data  = $urandom;
            cyc();
        end
        idle_cycles(3);

        // Reset mid-fetch
        fetch(32'h0);
        fetch(32'h4);
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        for (int k = 0; k < 2; k++) begin
            chk("async_rst_valid", 32'(val[k]), 32'd0);
            chk("async_rst_data", dat[k], 32'd0);
        end
        idle_cycles(2);
        rst_n = 1'b1;
        fetch(32'h8);
        idle_cycles(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/inst_mem_sync.md
Name: inst_mem_sync

Overview:
- Parametrised, synchronous successor to the combinational instruction ROM in the pipelined MIPS core.
- Word-addressed instruction store with a registered read pipeline of 1 or 2 stages, fetch stall and flush support, and a load port that writes the program image at run time.
- Sits between the IF-stage PC and the IF/ID register.
- Out-of-range and misaligned fetches return a fixed fill word and raise a flag.

Parameters:
- DATA_W, 32, instruction width in bits
- ADDR_W, 32, byte-address width
- DEPTH, 128, number of words; power of two; index = addr[log2(DEPTH)+1:2]
- READ_LAT, 1, read latency in cycles; legal values 1 or 2
- FILL_WORD, 32'h8000_0000, word returned for out-of-range or misaligned fetch

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request
- if_addr  in  ADDR_W  fetch byte address
- if_ready  out  1  fetch accepted this cycle when if_req && if_ready
- if_stall  in  1  downstream stall; freezes pipeline and outputs
- if_flush  in  1  kill all in-flight fetches (branch/jump taken)
- if_valid  out  1  if_data holds a live instruction
- if_data  out  DATA_W  fetched instruction
- if_err  out  1  qualifies if_valid; fetch was misaligned or out of range
- ld_we  in  1  program-load write strobe
- ld_addr  in  ADDR_W  load byte address
- ld_data  in  DATA_W  load data
- ld_err  out  1  one-cycle pulse: load write dropped (misaligned or out of range)

Behaviour:
- Reset (async, rst_n low) clears all pipeline state: if_valid=0, if_data=0, if_err=0, ld_err=0. Memory contents are not reset.
- if_ready = !if_stall && !ld_we. Load writes take priority over fetches.
- Accepted fetch: if_valid and if_data appear exactly READ_LAT cycles later, counting unstalled cycles only. Throughput is one fetch per cycle.
- Range and alignment check:
  - Address in range when addr < DEPTH*4. Aligned when addr[1:0]==0.
  - A failing fetch delivers if_data=FILL_WORD and if_err=1 with normal latency.
- if_stall high: all stage registers and outputs hold their values. No new request is accepted.
- if_flush high:
  - Clears the valid bit of every in-flight stage and if_valid on the next edge.
  - A request accepted in the same cycle as the flush is kept (it is the new target).
  - Flush overrides stall.
- Load write:
  - ld_we with a legal address writes memory on the rising edge.
  - An illegal address is dropped, and ld_err pulses high one cycle later.
- Read/write collision: a fetch to an address written in an earlier cycle returns the new data. A fetch cannot coincide with a write, because if_ready is low while ld_we is high.
- READ_LAT=2: stage 1 registers the array read; stage 2 registers the output. The err and valid bits travel alongside the data.
- Reset mid-operation: in-flight fetches are lost. After release, the first accepted fetch completes normally.

Optional Feature:
- INST_MEM_PARITY_EN
  - Defined: each word stores an even-parity bit computed on load. The read path recomputes parity, and a mismatch sets if_err together with if_valid; if_data is the raw stored word.
  - Undefined: no parity storage; if_err reflects only range and alignment.

Decomposition:
- Package inst_mem_pkg holds:
  - the FILL_WORD constant
  - an address-check function returning {in_range, aligned}
  - a parity function
  - a stage struct typedef {valid, err, data}
- Sub-module inst_mem_array: single-port-write, single-port-read storage with a registered read. Parameters DEPTH and DATA_W; optional parity column under INST_MEM_PARITY_EN.
- The top level holds the handshake, flush/stall logic and the READ_LAT output stage.

Test Plan:
- Load-then-fetch: load words 0..3 with 0x20020010, 0x2003000A, 0x20070000, 0x00000000, then fetch addresses 0x0,0x4,0x8,0xC back-to-back.
  - Response: same four words on if_data, if_valid high for 4 consecutive cycles, starting READ_LAT cycles after the first accept, with if_err=0.
- Range and alignment (DEPTH=128):
  - Fetch 0x200 -> if_data=0x80000000, if_err=1.
  - Fetch 0x6 -> if_data=0x80000000, if_err=1.
  - Load to 0x201 -> ld_err pulses once; memory unchanged.
- Stall: stall for 3 cycles with 2 fetches in flight (READ_LAT=2).
  - Response: if_data and if_valid frozen during the stall, if_ready=0, and both instructions delivered in order after release.
- Flush: flush in the cycle after a fetch of 0x10, while a new fetch of 0x40 is accepted in the flush cycle.
  - Response: the 0x10 result never appears with if_valid; the 0x40 result does.
- Load priority: ld_we and if_req both high.
  - Response: if_ready=0 and the write completes. A fetch of the same address in the next cycle returns the new value.
- Reset mid-fetch: drop rst_n while if_valid=1.
  - Response: if_valid=0 and if_data=0 immediately (asynchronously). With INST_MEM_PARITY_EN, a word with a forced parity-bit flip returns if_err=1.
